// File: rtl/dma_register_read_port_pkg.sv
// Shared register-configuration definitions for the DMA register read/write paths:
// widths, register addresses, FSM state encoding, status register layout, byte select.
package dma_register_read_port_pkg;

  localparam int CHANNELS     = 4;
  localparam int ADDRESSWIDTH = 16;
  localparam int DATAWIDTH    = 8;

  // Address 13 reads the temporary register and, when written, is the master clear.
  localparam logic [3:0] STATUS_ADDR   = 4'd8;
  localparam logic [3:0] CLEAR_FF_ADDR = 4'd12;
  localparam logic [3:0] TEMP_ADDR     = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } portState_t;

  typedef struct packed {
    logic [CHANNELS-1:0] dreq;
    logic [CHANNELS-1:0] tc;
  } statusReg_t;

  function automatic logic [DATAWIDTH-1:0] byteSelect(
    input logic [ADDRESSWIDTH-1:0] word,
    input logic                    highByte
  );
    return highByte ? word[2*DATAWIDTH-1:DATAWIDTH] : word[DATAWIDTH-1:0];
  endfunction

endpackage

// File: rtl/dma_register_read_port_if.sv
// CPU I/O bus as seen by the DMA register file: strobes, register address, read data.
interface dma_register_read_port_if;
  import dma_register_read_port_pkg::*;

  logic                 csN;
  logic                 iorN;
  logic                 iowN;
  logic [3:0]           address;
  logic [DATAWIDTH-1:0] dataOut;
  logic                 dataOutEnable;

  modport master (
    output csN, iorN, iowN, address,
    input  dataOut, dataOutEnable
  );

  modport slave (
    input  csN, iorN, iowN, address,
    output dataOut, dataOutEnable
  );

endinterface

// File: rtl/dma_register_read_port.sv
// CPU read path of the DMA register set: read decode, shared byte-pointer flip-flop,
// status TC bits and master-clear pulse.
module dma_register_read_port
  import dma_register_read_port_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  resetN,
  dma_register_read_port_if.slave               cpu,
  input  logic [CHANNELS-1:0][ADDRESSWIDTH-1:0] currentAddress,
  input  logic [CHANNELS-1:0][ADDRESSWIDTH-1:0] currentWordCount,
  input  logic [DATAWIDTH-1:0]                  temporary,
  input  logic [CHANNELS-1:0]                   dreqSensed,
  input  logic [CHANNELS-1:0]                   tcEvent,
  output logic                                  bytePointer,
  output logic                                  masterClear,
  output logic [CHANNELS-1:0]                   statusTC,
  output portState_t                            stateDbg
);

  // Bus protocol: a cycle is active while csN and its strobe are low, sampled on every
  // clk; it begins on the first sampled active clk and ends on the first inactive one.
  // Read and write strobes together are ignored entirely.
  logic readActive;
  logic writeActive;
  assign readActive  = ~cpu.csN & ~cpu.iorN &  cpu.iowN;
  assign writeActive = ~cpu.csN & ~cpu.iowN &  cpu.iorN;

  portState_t state;
  portState_t stateNext;
  logic       startRead;
  logic       startWrite;
  logic       endRead;
  logic       endWrite;
  logic       readEnable;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (readActive)       stateNext = READ;
        else if (writeActive) stateNext = WRITE;
      end
      READ:    if (!readActive)  stateNext = IDLE;
      WRITE:   if (!writeActive) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    startRead  = 1'b0;
    startWrite = 1'b0;
    endRead    = 1'b0;
    endWrite   = 1'b0;
    readEnable = 1'b0;
    case (state)
      IDLE: begin
        startRead  = readActive;
        startWrite = writeActive;
      end
      READ: begin
        readEnable = 1'b1;
        endRead    = ~readActive;
      end
      WRITE:   endWrite = ~writeActive;
      default: ;
    endcase
  end

  assign stateDbg = state;

  statusReg_t           statusWord;
  logic [DATAWIDTH-1:0] readData;
  assign statusWord = '{dreq: dreqSensed, tc: statusTC};

  always_comb begin
    readData = '0;
    if (!cpu.address[3]) begin
      readData = byteSelect(cpu.address[0] ? currentWordCount[cpu.address[2:1]]
                                           : currentAddress[cpu.address[2:1]],
                            bytePointer);
    end else if (cpu.address == STATUS_ADDR) begin
      readData = statusWord;
    end else if (cpu.address == TEMP_ADDR) begin
      readData = temporary;
    end
  end

  logic [3:0]           latchedAddr;
  logic [DATAWIDTH-1:0] dataOutReg;
  logic                 latchedIsChannel;
  logic                 tcClear;

  assign latchedIsChannel = ~latchedAddr[3];
  assign tcClear = (endRead  && latchedAddr == STATUS_ADDR) ||
                   (endWrite && latchedAddr == TEMP_ADDR);

  // dataOut keeps its captured value after the read ends; only the enable drops.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      latchedAddr <= '0;
      dataOutReg  <= '0;
      bytePointer <= 1'b0;
      masterClear <= 1'b0;
      statusTC    <= '0;
    end else begin
      if (startRead || startWrite) latchedAddr <= cpu.address;
      if (startRead)               dataOutReg  <= readData;
      if ((endRead || endWrite) && latchedIsChannel) begin
        bytePointer <= ~bytePointer;
      end else if (endWrite && (latchedAddr == CLEAR_FF_ADDR || latchedAddr == TEMP_ADDR)) begin
        bytePointer <= 1'b0;
      end
      masterClear <= endWrite && (latchedAddr == TEMP_ADDR);
      // A terminal count arriving alongside the clear survives it.
      statusTC    <= (tcClear ? '0 : statusTC) | tcEvent;
    end
  end

  assign cpu.dataOut       = dataOutReg;
  assign cpu.dataOutEnable = readEnable;

endmodule

// File: tb/tb_dma_register_read_port.sv
// Directed and randomized checks of the DMA register read port against a register-level model.
module tb_dma_register_read_port;
  import dma_register_read_port_pkg::*;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  dma_register_read_port_if cpu();

  logic [3:0][15:0] ca;
  logic [3:0][15:0] wc;
  logic [7:0]       temp;
  logic [3:0]       dreq;
  logic [3:0]       tc;
  logic             bytePointer;
  logic             masterClear;
  logic [3:0]       statusTC;
  portState_t       stateDbg;

  dma_register_read_port dut (
    .clk              (clk),
    .resetN           (resetN),
    .cpu              (cpu),
    .currentAddress   (ca),
    .currentWordCount (wc),
    .temporary        (temp),
    .dreqSensed       (dreq),
    .tcEvent          (tc),
    .bytePointer      (bytePointer),
    .masterClear      (masterClear),
    .statusTC         (statusTC),
    .stateDbg         (stateDbg)
  );

  int checks   = 0;
  int failures = 0;

  // Model: the byte pointer and TC bits, everything else is the register inputs themselves.
  logic       mBp;
  logic [3:0] mTc;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expRead(input logic [3:0] a);
    int         regNum;
    logic [15:0] word;
    regNum = int'(a);
    if (regNum < 8) begin
      word = (regNum % 2 == 1) ? wc[regNum / 2] : ca[regNum / 2];
      return mBp ? word[15:8] : word[7:0];
    end
    if (regNum == 8)  return {dreq, mTc};
    if (regNum == 13) return temp;
    return 8'h00;
  endfunction

  task automatic scramble();
    for (int i = 0; i < 4; i++) begin
      ca[i] = 16'($urandom);
      wc[i] = 16'($urandom);
    end
    temp = 8'($urandom);
    dreq = 4'($urandom);
  endtask

  task automatic doRead(input logic [3:0] a, input int hold, input logic [3:0] tcAtEnd,
                        output logic [7:0] got);
    logic [7:0] e;
    cpu.csN = 1'b0; cpu.iorN = 1'b0; cpu.address = a;
    e = expRead(a);
    @(negedge clk);
    got = cpu.dataOut;
    check("rd_enable", 16'(cpu.dataOutEnable), 16'(1));
    check("rd_data", 16'(cpu.dataOut), 16'(e));
    for (int h = 0; h < hold; h++) begin
      scramble();
      cpu.address = 4'($urandom);
      @(negedge clk);
      check("rd_hold", 16'(cpu.dataOut), 16'(e));
    end
    cpu.csN = 1'b1; cpu.iorN = 1'b1; tc = tcAtEnd;
    @(negedge clk);
    tc = '0;
    if (int'(a) < 8) mBp = ~mBp;
    if (a == 4'd8)   mTc = '0;
    mTc = mTc | tcAtEnd;
    check("rd_end_enable", 16'(cpu.dataOutEnable), 16'(0));
    check("rd_end_data", 16'(cpu.dataOut), 16'(e));
    check("rd_end_bp", 16'(bytePointer), 16'(mBp));
    check("rd_end_tc", 16'(statusTC), 16'(mTc));
  endtask

  task automatic doWrite(input logic [3:0] a);
    logic mcExp;
    cpu.csN = 1'b0; cpu.iowN = 1'b0; cpu.address = a;
    @(negedge clk);
    check("wr_enable", 16'(cpu.dataOutEnable), 16'(0));
    cpu.csN = 1'b1; cpu.iowN = 1'b1;
    @(negedge clk);
    mcExp = (a == 4'd13);
    if (int'(a) < 8)                mBp = ~mBp;
    if (a == 4'd12 || a == 4'd13)   mBp = 1'b0;
    if (a == 4'd13)                 mTc = '0;
    check("wr_mc", 16'(masterClear), 16'(mcExp));
    check("wr_bp", 16'(bytePointer), 16'(mBp));
    check("wr_tc", 16'(statusTC), 16'(mTc));
    @(negedge clk);
    check("wr_mc_after", 16'(masterClear), 16'(0));
  endtask

  task automatic pulseTc(input logic [3:0] v);
    tc = v;
    @(negedge clk);
    tc = '0;
    mTc = mTc | v;
    check("tc_set", 16'(statusTC), 16'(mTc));
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_data"}, 16'(cpu.dataOut), 16'(0));
    check({tag, "_en"},   16'(cpu.dataOutEnable), 16'(0));
    check({tag, "_bp"},   16'(bytePointer), 16'(0));
    check({tag, "_mc"},   16'(masterClear), 16'(0));
    check({tag, "_tc"},   16'(statusTC), 16'(0));
    check({tag, "_st"},   16'(stateDbg), 16'(IDLE));
  endtask

  initial begin
    logic [7:0] got;
    resetN = 1'b0;
    cpu.csN = 1'b1; cpu.iorN = 1'b1; cpu.iowN = 1'b1; cpu.address = '0;
    ca = '0; wc = '0; temp = '0; dreq = '0; tc = '0;
    mBp = 1'b0; mTc = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    resetN = 1'b1;
    @(negedge clk);

    // Two-byte read of channel 2 current address.
    ca[2] = 16'hABCD;
    doRead(4'd4, 0, 4'b0000, got);
    check("t1_low", 16'(got), 16'h00CD);
    doRead(4'd4, 1, 4'b0000, got);
    check("t1_high", 16'(got), 16'h00AB);
    check("t1_bp", 16'(bytePointer), 16'(0));

    // Clear byte pointer then single low-byte read of word count 3.
    doWrite(4'd12);
    wc[3] = 16'h1234;
    doRead(4'd7, 0, 4'b0000, got);
    check("t2_data", 16'(got), 16'h0034);
    check("t2_bp", 16'(bytePointer), 16'(1));

    // Status read and clear-on-read.
    dreq = 4'b1000;
    pulseTc(4'b0101);
    doRead(4'd8, 0, 4'b0000, got);
    check("t3_data", 16'(got), 16'h0085);
    check("t3_tc", 16'(statusTC), 16'(0));

    // TC arriving in the end-of-status-read cycle survives the clear.
    pulseTc(4'b0001);
    doRead(4'd8, 0, 4'b0010, got);
    check("t4_data", 16'(got), 16'h0081);
    check("t4_tc", 16'(statusTC), 16'h0002);

    // Master clear with byte pointer set and all TC bits set.
    check("t5_bp_pre", 16'(bytePointer), 16'(1));
    pulseTc(4'b1111);
    doWrite(4'd13);
    check("t5_bp", 16'(bytePointer), 16'(0));
    check("t5_tc", 16'(statusTC), 16'(0));

    // Simultaneous read and write strobes are ignored.
    cpu.csN = 1'b0; cpu.iorN = 1'b0; cpu.iowN = 1'b0; cpu.address = 4'd0;
    @(negedge clk);
    check("both_en", 16'(cpu.dataOutEnable), 16'(0));
    check("both_st", 16'(stateDbg), 16'(IDLE));
    cpu.csN = 1'b1; cpu.iorN = 1'b1; cpu.iowN = 1'b1;
    @(negedge clk);
    check("both_bp", 16'(bytePointer), 16'(mBp));
    check("both_mc", 16'(masterClear), 16'(0));

    // Randomized mix of reads, writes and terminal-count pulses.
    for (int n = 0; n < 80; n++) begin
      int op;
      scramble();
      op = int'($urandom_range(0, 3));
      if (op <= 1) begin
        doRead(4'($urandom), int'($urandom_range(0, 2)),
               ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000, got);
      end else if (op == 2) begin
        doWrite(4'($urandom));
      end else begin
        pulseTc(4'($urandom));
      end
    end

    // Reset in the middle of a read of address 0.
    doWrite(4'd12);
    pulseTc(4'b0110);
    cpu.csN = 1'b0; cpu.iorN = 1'b0; cpu.address = 4'd0;
    @(negedge clk);
    check("rst_rd_en", 16'(cpu.dataOutEnable), 16'(1));
    #2 resetN = 1'b0;
    #1 checkAllZero("rst_mid");
    cpu.csN = 1'b1; cpu.iorN = 1'b1;
    @(negedge clk);
    resetN = 1'b1;
    mBp = 1'b0; mTc = '0;
    @(negedge clk);
    check("rst_after_bp", 16'(bytePointer), 16'(mBp));
    check("rst_after_tc", 16'(statusTC), 16'(mTc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
